// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 state encodings, protocol constants and parity helper
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_TX_INHIBIT,
    ST_TX_RTS,
    ST_TX_BITS,
    ST_TX_ACK,
    ST_TX_WAIT_IDLE
  } ps2_state_e;

  localparam logic [7:0] PS2_ACK         = 8'hFA;
  localparam logic [7:0] PS2_RESEND      = 8'hFE;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_CMD_RATE    = 8'hF3;

  // Parity bit that makes the 9-bit {data, parity} group contain an odd number of ones
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-FF synchroniser for PS/2 clock and data with clock falling-edge detect
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_s,
  output logic data_s,
  output logic clk_fall
);

  logic [1:0] clk_ff_q, clk_ff_d;
  logic [1:0] data_ff_q, data_ff_d;
  logic       clk_prev_q, clk_prev_d;

  // Shift the raw pad values through two stages; keep the previous synced clock for edge detect
  always_comb begin
    clk_ff_d   = {clk_ff_q[0], clk_in};
    data_ff_d  = {data_ff_q[0], data_in};
    clk_prev_d = clk_ff_q[1];
  end

  // Idle bus level is high, so reset every stage to 1 to avoid a false edge after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_ff_q   <= 2'b11;
      data_ff_q  <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_ff_q   <= clk_ff_d;
      data_ff_q  <= data_ff_d;
      clk_prev_q <= clk_prev_d;
    end
  end

  assign clk_s    = clk_ff_q[1];
  assign data_s   = data_ff_q[1];
  assign clk_fall = clk_prev_q & ~clk_ff_q[1];

endmodule

// File: rtl/ps2_host_ctrl.sv
// rtl/ps2_host_ctrl.sv - bidirectional PS/2 host engine with packet assembly and error checking
module ps2_host_ctrl
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int PKT_BYTES      = 3,
  parameter int ALIGN_BIT3     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  inout  wire                    ps2_clk,
  inout  wire                    ps2_data,
  input  logic [7:0]             cmd_data,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  output logic [7:0]             rx_byte,
  output logic                   rx_byte_valid,
  output logic [8*PKT_BYTES-1:0] pkt_data,
  output logic                   pkt_valid,
  output logic                   err_parity,
  output logic                   err_frame,
  output logic                   err_timeout,
  output logic                   tx_nack,
  output logic                   busy
);

  localparam logic [31:0] INHIBIT_LAST = 32'(INHIBIT_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  IDX_LAST     = 2'(PKT_BYTES - 1);

  logic clk_s, data_s, clk_fall;

  ps2_line_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .clk_in   (ps2_clk),
    .data_in  (ps2_data),
    .clk_s    (clk_s),
    .data_s   (data_s),
    .clk_fall (clk_fall)
  );

  ps2_state_e             state_q, state_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [1:0]             idx_q, idx_d;
  logic [8*PKT_BYTES-1:0] buf_q, buf_d;
  logic [8*PKT_BYTES-1:0] pkt_q, pkt_d;
  logic [7:0]             rx_byte_q, rx_byte_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   pkt_valid_q, pkt_valid_d;
  logic                   err_par_q, err_par_d;
  logic                   err_frm_q, err_frm_d;
  logic                   err_to_q, err_to_d;
  logic                   nack_q, nack_d;
  logic                   clk_oe_q, clk_oe_d;
  logic                   data_oe_q, data_oe_d;
  logic [8*PKT_BYTES-1:0] asm_pkt;
  logic                   wd_on;

  // Next-state logic for the transceiver FSM, packet assembler and watchdog
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    par_d       = par_q;
    bit_cnt_d   = bit_cnt_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    pkt_d       = pkt_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    pkt_valid_d = 1'b0;
    err_par_d   = 1'b0;
    err_frm_d   = 1'b0;
    err_to_d    = 1'b0;
    nack_d      = 1'b0;
    clk_oe_d    = clk_oe_q;
    data_oe_d   = data_oe_q;

    asm_pkt = buf_q;
    asm_pkt[{idx_q, 3'b000} +: 8] = shift_q;

    // Watchdog: the edge cycle counts as the first cycle of the gap
    wd_on = (state_q == ST_RX) || (state_q == ST_TX_BITS) ||
            (state_q == ST_TX_ACK) || (state_q == ST_TX_WAIT_IDLE);
    if (wd_on) cnt_d = clk_fall ? 32'd1 : cnt_q + 32'd1;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (clk_fall) begin
          if (data_s) begin
            err_frm_d = 1'b1;
          end else begin
            state_d   = ST_RX;
            bit_cnt_d = '0;
            cnt_d     = 32'd1;
          end
        end else if (cmd_valid) begin
          shift_d  = cmd_data;
          par_d    = odd_parity(cmd_data);
          idx_d    = '0;
          clk_oe_d = 1'b1;
          state_d  = ST_TX_INHIBIT;
        end
      end
      ST_RX: begin
        if (clk_fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q < 4'd8) begin
            shift_d = {data_s, shift_q[7:1]};
          end else if (bit_cnt_q == 4'd8) begin
            par_d = data_s;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (!(^{shift_q, par_q})) begin
              err_par_d = 1'b1;
              idx_d     = '0;
            end else if (!data_s) begin
              err_frm_d = 1'b1;
              idx_d     = '0;
            end else begin
              rx_valid_d = 1'b1;
              rx_byte_d  = shift_q;
              // An unaligned first byte is reported but never enters the packet
              if (!((ALIGN_BIT3 != 0) && (idx_q == 2'd0) && !shift_q[3])) begin
                buf_d = asm_pkt;
                if (idx_q == IDX_LAST) begin
                  pkt_d       = asm_pkt;
                  pkt_valid_d = 1'b1;
                  idx_d       = '0;
                end else begin
                  idx_d = idx_q + 2'd1;
                end
              end
            end
          end
        end
      end
      ST_TX_INHIBIT: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == INHIBIT_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          state_d   = ST_TX_RTS;
        end
      end
      ST_TX_RTS: begin
        bit_cnt_d = '0;
        cnt_d     = 32'd1;
        state_d   = ST_TX_BITS;
      end
      ST_TX_BITS: begin
        if (clk_fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q < 4'd8)       data_oe_d = ~shift_q[bit_cnt_q[2:0]];
          else if (bit_cnt_q == 4'd8) data_oe_d = ~par_q;
          else if (bit_cnt_q == 4'd9) data_oe_d = 1'b0;
          else                        state_d   = ST_TX_ACK;
        end
      end
      ST_TX_ACK: begin
        if (clk_fall) begin
          nack_d  = data_s;
          state_d = ST_TX_WAIT_IDLE;
        end
      end
      ST_TX_WAIT_IDLE: begin
        if (clk_s && data_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wd_on && !clk_fall && (cnt_q == TIMEOUT_LAST)) begin
      state_d     = ST_IDLE;
      err_to_d    = 1'b1;
      err_par_d   = 1'b0;
      err_frm_d   = 1'b0;
      rx_valid_d  = 1'b0;
      pkt_valid_d = 1'b0;
      nack_d      = 1'b0;
      clk_oe_d    = 1'b0;
      data_oe_d   = 1'b0;
      idx_d       = '0;
      cnt_d       = '0;
    end
  end

  // Register all state and outputs; reset releases the lines and clears everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      par_q       <= 1'b0;
      bit_cnt_q   <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      buf_q       <= '0;
      pkt_q       <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      pkt_valid_q <= 1'b0;
      err_par_q   <= 1'b0;
      err_frm_q   <= 1'b0;
      err_to_q    <= 1'b0;
      nack_q      <= 1'b0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      bit_cnt_q   <= bit_cnt_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      pkt_q       <= pkt_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      pkt_valid_q <= pkt_valid_d;
      err_par_q   <= err_par_d;
      err_frm_q   <= err_frm_d;
      err_to_q    <= err_to_d;
      nack_q      <= nack_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
    end
  end

  assign ps2_clk  = clk_oe_q  ? 1'b0 : 1'bz;
  assign ps2_data = data_oe_q ? 1'b0 : 1'bz;

  // A device edge in IDLE takes priority over a pending command
  assign cmd_ready     = (state_q == ST_IDLE) && !clk_fall;
  assign busy          = (state_q != ST_IDLE);
  assign rx_byte       = rx_byte_q;
  assign rx_byte_valid = rx_valid_q;
  assign pkt_data      = pkt_q;
  assign pkt_valid     = pkt_valid_q;
  assign err_parity    = err_par_q;
  assign err_frame     = err_frm_q;
  assign err_timeout   = err_to_q;
  assign tx_nack       = nack_q;

endmodule
